// File: rtl/dp_register_file.sv
// 32-entry MIPS general-purpose register file: two combinational datapath read
// ports, one debug read port, one clocked write port, $0 hardwired to zero.
module dp_register_file #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned FORWARD = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       ReadReg1,
   input  logic [4:0]       ReadReg2,
   input  logic [4:0]       WriteReg,
   input  logic [WIDTH-1:0] WriteData,
   input  logic             RegWrite,
   input  logic [4:0]       DebugReg,
   output logic [WIDTH-1:0] ReadData1,
   output logic [WIDTH-1:0] ReadData2,
   output logic [WIDTH-1:0] DebugData
);

   localparam int unsigned NREGS = 32;
   localparam int unsigned IDXW  = 5;

   // Entry 0 has no storage; it is synthesised as a constant zero on every read.
   logic [WIDTH-1:0] regs_q [1:NREGS-1];
   logic [WIDTH-1:0] regs_d [1:NREGS-1];

   logic             we_c;
   logic [WIDTH-1:0] arr1_c;
   logic [WIDTH-1:0] arr2_c;
   logic [WIDTH-1:0] arrd_c;

   assign we_c = RegWrite && !rst && (WriteReg != '0);

   always_comb begin
      regs_d = regs_q;
      for (int i = 1; i < int'(NREGS); i++) begin
         if (we_c && (WriteReg == IDXW'(i))) begin
            regs_d[i] = WriteData;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Array lookups; index 0 falls through to the zero default.
   always_comb begin
      arr1_c = '0;
      arr2_c = '0;
      arrd_c = '0;
      for (int i = 1; i < int'(NREGS); i++) begin
         if (ReadReg1 == IDXW'(i)) arr1_c = regs_q[i];
         if (ReadReg2 == IDXW'(i)) arr2_c = regs_q[i];
         if (DebugReg == IDXW'(i)) arrd_c = regs_q[i];
      end
   end

   // we_c already excludes $0 and reset, so a bypass can never leak a value onto index 0.
   always_comb begin
      ReadData1 = arr1_c;
      ReadData2 = arr2_c;
      DebugData = arrd_c;
      if ((FORWARD != 0) && we_c && (WriteReg == ReadReg1)) ReadData1 = WriteData;
      if ((FORWARD != 0) && we_c && (WriteReg == ReadReg2)) ReadData2 = WriteData;
      if (rst) begin
         ReadData1 = '0;
         ReadData2 = '0;
         DebugData = '0;
      end
   end

endmodule

// File: tb/tb_dp_register_file.sv
// Bench for dp_register_file: a non-forwarding and a forwarding instance share
// all inputs; expected port values are queued and compared against captures.
module tb_dp_register_file;

   localparam int unsigned W = 32;

   typedef struct {
      string      tag;
      logic [W-1:0] val;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [4:0]   rr1 = '0, rr2 = '0, wr = '0, dr = '0;
   logic [W-1:0] wd = '0;
   logic         we = 1'b0;
   logic [W-1:0] n_rd1, n_rd2, n_dbg, f_rd1, f_rd2, f_dbg;

   exp_t         exp_q[$];
   logic [W-1:0] obs_q[$];
   logic [W-1:0] model [32];
   int           errors = 0;
   int           checks = 0;

   dp_register_file #(.WIDTH(W), .FORWARD(0)) u_nf (
      .clk(clk), .rst(rst), .ReadReg1(rr1), .ReadReg2(rr2), .WriteReg(wr),
      .WriteData(wd), .RegWrite(we), .DebugReg(dr),
      .ReadData1(n_rd1), .ReadData2(n_rd2), .DebugData(n_dbg));

   dp_register_file #(.WIDTH(W), .FORWARD(1)) u_fw (
      .clk(clk), .rst(rst), .ReadReg1(rr1), .ReadReg2(rr2), .WriteReg(wr),
      .WriteData(wd), .RegWrite(we), .DebugReg(dr),
      .ReadData1(f_rd1), .ReadData2(f_rd2), .DebugData(f_dbg));

   always #5 clk = ~clk;

   // Reference value of one read port from the architectural model.
   function automatic logic [W-1:0] port_exp(input logic [4:0] idx, input bit fwd);
      if (rst || idx == 5'd0) return '0;
      if (fwd && we && wr != 5'd0 && wr == idx) return wd;
      return model[idx];
   endfunction

   task automatic push6(input string tag, input logic [W-1:0] a, b, c, d, e, f);
      exp_q.push_back('{{tag, ".nf_rd1"}, a});
      exp_q.push_back('{{tag, ".nf_rd2"}, b});
      exp_q.push_back('{{tag, ".nf_dbg"}, c});
      exp_q.push_back('{{tag, ".fw_rd1"}, d});
      exp_q.push_back('{{tag, ".fw_rd2"}, e});
      exp_q.push_back('{{tag, ".fw_dbg"}, f});
   endtask

   task automatic push_model(input string tag);
      push6(tag, port_exp(rr1, 0), port_exp(rr2, 0), port_exp(dr, 0),
            port_exp(rr1, 1), port_exp(rr2, 1), port_exp(dr, 0));
   endtask

   task automatic capture();
      obs_q.push_back(n_rd1); obs_q.push_back(n_rd2); obs_q.push_back(n_dbg);
      obs_q.push_back(f_rd1); obs_q.push_back(f_rd2); obs_q.push_back(f_dbg);
   endtask

   // Rising edge with the model committing the same write the DUT should.
   task automatic edge_update();
      @(posedge clk);
      if (we && !rst && wr != 5'd0) model[wr] = wd;
      #1;
   endtask

   task automatic write_reg(input logic [4:0] r, input logic [W-1:0] v);
      @(negedge clk);
      wr = r; wd = v; we = 1'b1;
      edge_update();
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e; logic [W-1:0] o;
      #2 rst = 1'b1;
      foreach (model[i]) model[i] = '0;
      #1;
      rr1 = 5'd1; rr2 = 5'd2; dr = 5'd3;
      push6("reset_hold", 0, 0, 0, 0, 0, 0);
      capture();
      @(negedge clk) rst = 1'b0;
      write_reg(5'd5, 32'hDEADBEEF);
      dr = 5'd5; #1;
      push6("r5_written", port_exp(rr1, 0), port_exp(rr2, 0), 32'hDEADBEEF,
            port_exp(rr1, 1), port_exp(rr2, 1), 32'hDEADBEEF);
      capture();
      #1 rst = 1'b1;
      foreach (model[i]) model[i] = '0;
      #1;
      push6("reset_midcycle", 0, 0, 0, 0, 0, 0);
      capture();
      #1 rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rr1 = 5'(i); rr2 = 5'(31 - i); dr = 5'(i); #1;
         push6($sformatf("post_reset_r%0d", i), 0, 0, 0, 0, 0, 0);
         capture();
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, o, e.val); end
      end
   endtask

   task automatic test_basic_write();
      exp_t e; logic [W-1:0] o;
      write_reg(5'd8, 32'h12345678);
      write_reg(5'd31, 32'hFFFFFFFF);
      rr1 = 5'd8; rr2 = 5'd31; dr = 5'd8; #1;
      push6("basic", 32'h12345678, 32'hFFFFFFFF, 32'h12345678,
            32'h12345678, 32'hFFFFFFFF, 32'h12345678);
      capture();
      @(negedge clk);
      wr = 5'd8; wd = 32'h1; we = 1'b0;
      edge_update();
      push6("regwrite_off", 32'h12345678, 32'hFFFFFFFF, 32'h12345678,
            32'h12345678, 32'hFFFFFFFF, 32'h12345678);
      capture();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, o, e.val); end
      end
   endtask

   task automatic test_zero_reg();
      exp_t e; logic [W-1:0] o;
      @(negedge clk);
      rr1 = 5'd0; rr2 = 5'd0; dr = 5'd0;
      wr = 5'd0; wd = 32'hAAAAAAAA; we = 1'b1; #1;
      push6("r0_before_edge", 0, 0, 0, 0, 0, 0);
      capture();
      edge_update();
      push6("r0_after_edge", 0, 0, 0, 0, 0, 0);
      capture();
      @(negedge clk) we = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, o, e.val); end
      end
   endtask

   task automatic test_same_cycle();
      exp_t e; logic [W-1:0] o;
      write_reg(5'd3, 32'h11);
      @(negedge clk);
      wr = 5'd3; wd = 32'h22; we = 1'b1;
      rr1 = 5'd3; rr2 = 5'd3; dr = 5'd3; #1;
      push6("same_before", 32'h11, 32'h11, 32'h11, 32'h22, 32'h22, 32'h11);
      capture();
      edge_update();
      push6("same_after", 32'h22, 32'h22, 32'h22, 32'h22, 32'h22, 32'h22);
      capture();
      @(negedge clk) we = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, o, e.val); end
      end
   endtask

   task automatic test_reset_write();
      exp_t e; logic [W-1:0] o;
      write_reg(5'd7, 32'h99);
      @(negedge clk);
      wr = 5'd7; wd = 32'h55; we = 1'b1;
      rr1 = 5'd7; rr2 = 5'd7; dr = 5'd7;
      #3 rst = 1'b1;
      foreach (model[i]) model[i] = '0;
      #1;
      push6("rst_blocks_fwd", 0, 0, 0, 0, 0, 0);
      capture();
      edge_update();
      @(negedge clk);
      we = 1'b0; rst = 1'b0; #1;
      push6("rst_write_dropped", 0, 0, 0, 0, 0, 0);
      capture();
      write_reg(5'd7, 32'h66);
      #1;
      push6("write_after_release", 32'h66, 32'h66, 32'h66, 32'h66, 32'h66, 32'h66);
      capture();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, o, e.val); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e; logic [W-1:0] o;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         we  = ($urandom_range(0, 3) != 0);
         wr  = 5'($urandom_range(0, 31));
         wd  = $urandom();
         rr1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
         rr2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
         dr  = ($urandom_range(0, 1) == 0) ? wr : 5'($urandom_range(0, 31));
         #1;
         push_model($sformatf("b2b%0d_pre", n));
         capture();
         edge_update();
         push_model($sformatf("b2b%0d_post", n));
         capture();
      end
      @(negedge clk) we = 1'b0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e.val) begin errors++; $display("FAIL %s got=%h exp=%h", e.tag, o, e.val); end
      end
   endtask

   initial begin
      foreach (model[i]) model[i] = '0;
      test_reset();
      test_basic_write();
      test_zero_reg();
      test_same_cycle();
      test_reset_write();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
